// File: rtl/signal_window_monitor_if.sv
// Sample stream and result bus of the window monitor.
// The stream has no back-pressure. A sample is taken on every clock edge where
// sample_valid is high while a window is open. Other cycles are ignored.
interface signal_window_monitor_if #(
   parameter int WIDTH  = 16,
   parameter int N_LOG2 = 8
);
   logic                        start;
   logic                        sample_valid;
   logic [WIDTH-1:0]            signal_in;
   logic                        busy;
   logic                        done;
   logic [WIDTH-1:0]            min_out;
   logic [WIDTH-1:0]            max_out;
   logic [WIDTH+N_LOG2-1:0]     sum_out;
   logic [2*WIDTH+N_LOG2-1:0]   energy_out;
   logic [N_LOG2:0]             clip_count;
   logic                        state_dbg;

   modport master (
      output start, sample_valid, signal_in,
      input  busy, done, min_out, max_out, sum_out, energy_out, clip_count, state_dbg
   );

   modport slave (
      input  start, sample_valid, signal_in,
      output busy, done, min_out, max_out, sum_out, energy_out, clip_count, state_dbg
   );
endinterface

// File: rtl/signal_window_monitor.sv
// Measures min, max, sum, energy and full-scale count over one window of
// 2**N_LOG2 accepted signed samples. Results are published with a one-cycle done pulse.
module signal_window_monitor #(
   parameter int WIDTH  = 16,
   parameter int N_LOG2 = 8
) (
   input  logic                    clk_sampling,
   input  logic                    rst,
   signal_window_monitor_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   localparam logic [N_LOG2:0]        LAST_IDX = {1'b0, {N_LOG2{1'b1}}};
   localparam logic [N_LOG2:0]        CNT_ONE  = {{N_LOG2{1'b0}}, 1'b1};
   localparam logic signed [WIDTH-1:0] POS_FS  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] NEG_FS  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t state_q, state_d;
   logic   done_q, done_d;

   logic [N_LOG2:0]              cnt_q;
   logic signed [WIDTH-1:0]      min_q, max_q;
   logic [WIDTH+N_LOG2-1:0]      sum_q;
   logic [2*WIDTH+N_LOG2-1:0]    energy_q;
   logic [N_LOG2:0]              clip_q;

   logic signed [WIDTH-1:0]      min_res, max_res;
   logic [WIDTH+N_LOG2-1:0]      sum_res;
   logic [2*WIDTH+N_LOG2-1:0]    energy_res;
   logic [N_LOG2:0]              clip_res;

   logic signed [WIDTH-1:0]      sample;
   logic signed [2*WIDTH-1:0]    sample_wide;
   logic signed [2*WIDTH-1:0]    square;
   logic                         accept, last, is_clip;
   logic signed [WIDTH-1:0]      min_next, max_next;
   logic [WIDTH+N_LOG2-1:0]      sum_next;
   logic [2*WIDTH+N_LOG2-1:0]    energy_next;
   logic [N_LOG2:0]              clip_next;

   assign sample      = bus.signal_in;
   assign sample_wide = {{WIDTH{sample[WIDTH-1]}}, sample};
   // A square is never negative, so its bits are used directly as an unsigned value.
   assign square      = sample_wide * sample_wide;
   assign accept      = (state_q == ACCUM) && bus.sample_valid;
   assign last        = accept && (cnt_q == LAST_IDX);
   assign is_clip     = (sample == POS_FS) || (sample == NEG_FS);

   // The first accepted sample (cnt_q == 0) seeds min and max.
   assign min_next    = ((cnt_q == '0) || (sample < min_q)) ? sample : min_q;
   assign max_next    = ((cnt_q == '0) || (sample > max_q)) ? sample : max_q;
   assign sum_next    = sum_q + {{N_LOG2{sample[WIDTH-1]}}, sample};
   assign energy_next = energy_q + {{N_LOG2{1'b0}}, square};
   assign clip_next   = clip_q + {{N_LOG2{1'b0}}, is_clip};

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:  if (bus.start) state_d = ACCUM;
         ACCUM: if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sampling) begin
      if (rst) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         cnt_q      <= '0;
         min_q      <= '0;
         max_q      <= '0;
         sum_q      <= '0;
         energy_q   <= '0;
         clip_q     <= '0;
         min_res    <= '0;
         max_res    <= '0;
         sum_res    <= '0;
         energy_res <= '0;
         clip_res   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if ((state_q == IDLE) && bus.start) begin
            cnt_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            sum_q    <= '0;
            energy_q <= '0;
            clip_q   <= '0;
         end else if (accept) begin
            cnt_q    <= cnt_q + CNT_ONE;
            min_q    <= min_next;
            max_q    <= max_next;
            sum_q    <= sum_next;
            energy_q <= energy_next;
            clip_q   <= clip_next;
            if (last) begin
               min_res    <= min_next;
               max_res    <= max_next;
               sum_res    <= sum_next;
               energy_res <= energy_next;
               clip_res   <= clip_next;
            end
         end
      end
   end

   assign bus.busy       = (state_q == ACCUM);
   assign bus.done       = done_q;
   assign bus.state_dbg  = state_q;
   assign bus.min_out    = min_res;
   assign bus.max_out    = max_res;
   assign bus.sum_out    = sum_res;
   assign bus.energy_out = energy_res;
   assign bus.clip_count = clip_res;
endmodule
